// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Hazard controller for the 5-stage pipeline. It drives the select inputs of
// the operand forwarding muxes in the D and E stages, raises the F/D stall,
// and tracks how long the multicycle mult/div unit stays busy.
//
// Forwarding mux select codes:
//   0 = register value, 1 = EM ALU result, 2 = MW ALU result,
//   3 = MW MD result,    4 = MW CP0 result
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous reset, active low
//   d_rs_addr / d_rt_addr    D-stage source registers
//   d_tuse_rs / d_tuse_rt    cycles until D needs the operand (3 = unused)
//   d_is_md                  D instruction uses the mult/div unit
//   e_rs_addr / e_rt_addr    E-stage source registers
//   e_waddr / e_tnew         E-stage destination and cycles until ready
//   m_waddr / m_tnew         M-stage destination and cycles until ready
//   w_waddr / w_src          W-stage destination and result source
//   md_start / md_is_div     mult/div issue pulse and its kind
//   fwd_sel_*                forwarding mux selects
//   stall                    freeze PC and F/D, bubble into E
//   md_busy                  mult/div unit busy (registered)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs_addr,
   input  logic [4:0] d_rt_addr,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic       d_is_md,
   input  logic [4:0] e_rs_addr,
   input  logic [4:0] e_rt_addr,
   input  logic [4:0] e_waddr,
   input  logic [1:0] e_tnew,
   input  logic [4:0] m_waddr,
   input  logic [1:0] m_tnew,
   input  logic [4:0] w_waddr,
   input  logic [1:0] w_src,
   input  logic       md_start,
   input  logic       md_is_div,
   output logic [2:0] fwd_sel_d_rs,
   output logic [2:0] fwd_sel_d_rt,
   output logic [2:0] fwd_sel_e_rs,
   output logic [2:0] fwd_sel_e_rt,
   output logic       stall,
   output logic       md_busy
);

   typedef enum logic [2:0] {
      SEL_REG    = 3'd0,
      SEL_EM_ALU = 3'd1,
      SEL_MW_ALU = 3'd2,
      SEL_MW_MD  = 3'd3,
      SEL_MW_CP0 = 3'd4
   } fwd_sel_e;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Register 0 is hardwired to zero, so it never produces a hazard.
   function automatic logic addr_match(input logic [4:0] a, input logic [4:0] b);
      return (a == b) && (a != 5'd0);
   endfunction

   // M has priority over W because it holds the younger result. A memory
   // result in W selects the register file, whose write-through covers it.
   function automatic fwd_sel_e fwd_code(input logic [4:0] src,
                                         input logic [4:0] mw,
                                         input logic [1:0] mt,
                                         input logic [4:0] ww,
                                         input logic [1:0] ws);
      fwd_sel_e sel;
      sel = SEL_REG;
      if (addr_match(src, mw) && (mt == 2'd0)) begin
         sel = SEL_EM_ALU;
      end else if (addr_match(src, ww)) begin
         unique case (ws)
            2'd0:    sel = SEL_MW_ALU;
            2'd1:    sel = SEL_MW_MD;
            2'd2:    sel = SEL_MW_CP0;
            default: sel = SEL_REG;
         endcase
      end
      return sel;
   endfunction

   // A source stalls when a producer in E or M will not have its value ready
   // by the time the D instruction needs it.
   function automatic logic src_stall(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] ew,
                                      input logic [1:0] et,
                                      input logic [4:0] mw,
                                      input logic [1:0] mt);
      return (tuse != TUSE_NONE) &&
             ((addr_match(src, ew) && (tuse < et)) ||
              (addr_match(src, mw) && (tuse < mt)));
   endfunction

   logic [CNT_W-1:0] r_busy_cnt;
   logic             w_data_stall;
   logic             w_md_stall;

   // Busy counter: a new issue always reloads (never accumulates), otherwise
   // count down to zero and hold.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy_cnt <= '0;
      end else if (md_start) begin
         r_busy_cnt <= md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_busy_cnt != '0) begin
         r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
   end

   assign md_busy = (r_busy_cnt != '0);

   // The md_start term covers the issue cycle, before the counter is loaded.
   assign w_md_stall   = d_is_md && (md_start || md_busy);
   assign w_data_stall = src_stall(d_rs_addr, d_tuse_rs, e_waddr, e_tnew, m_waddr, m_tnew) ||
                         src_stall(d_rt_addr, d_tuse_rt, e_waddr, e_tnew, m_waddr, m_tnew);

   // NOTE: every output gets a default before any conditional assignment so
   // this block can never infer a latch.
   always_comb begin
      fwd_sel_d_rs = SEL_REG;
      fwd_sel_d_rt = SEL_REG;
      fwd_sel_e_rs = SEL_REG;
      fwd_sel_e_rt = SEL_REG;
      stall        = 1'b0;
      if (reset) begin
         fwd_sel_d_rs = fwd_code(d_rs_addr, m_waddr, m_tnew, w_waddr, w_src);
         fwd_sel_d_rt = fwd_code(d_rt_addr, m_waddr, m_tnew, w_waddr, w_src);
         fwd_sel_e_rs = fwd_code(e_rs_addr, m_waddr, m_tnew, w_waddr, w_src);
         fwd_sel_e_rt = fwd_code(e_rt_addr, m_waddr, m_tnew, w_waddr, w_src);
         stall        = w_data_stall || w_md_stall;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Self-checking bench for fwd_hazard_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural reference model. The model
// tracks the mult/div unit as "busy through cycle N" rather than as a counter.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs_addr, d_rt_addr, e_rs_addr, e_rt_addr;
   logic [1:0] d_tuse_rs, d_tuse_rt;
   logic       d_is_md;
   logic [4:0] e_waddr, m_waddr, w_waddr;
   logic [1:0] e_tnew, m_tnew, w_src;
   logic       md_start, md_is_div;
   logic [2:0] fwd_sel_d_rs, fwd_sel_d_rt, fwd_sel_e_rs, fwd_sel_e_rt;
   logic       stall, md_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int busy_end = -1;   // last cycle index in which the unit reads busy

   fwd_hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .d_rs_addr    (d_rs_addr),
      .d_rt_addr    (d_rt_addr),
      .d_tuse_rs    (d_tuse_rs),
      .d_tuse_rt    (d_tuse_rt),
      .d_is_md      (d_is_md),
      .e_rs_addr    (e_rs_addr),
      .e_rt_addr    (e_rt_addr),
      .e_waddr      (e_waddr),
      .e_tnew       (e_tnew),
      .m_waddr      (m_waddr),
      .m_tnew       (m_tnew),
      .w_waddr      (w_waddr),
      .w_src        (w_src),
      .md_start     (md_start),
      .md_is_div    (md_is_div),
      .fwd_sel_d_rs (fwd_sel_d_rs),
      .fwd_sel_d_rt (fwd_sel_d_rt),
      .fwd_sel_e_rs (fwd_sel_e_rs),
      .fwd_sel_e_rt (fwd_sel_e_rt),
      .stall        (stall),
      .md_busy      (md_busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [2:0] ref_sel(input logic [4:0] src);
      int w_code [4];
      w_code = '{2, 3, 4, 0};
      if (src != 0 && src == m_waddr && m_tnew == 0) return 3'd1;
      if (src != 0 && src == w_waddr) return 3'(w_code[w_src]);
      return 3'd0;
   endfunction

   function automatic logic ref_stall();
      int  addrs [2];
      int  tuses [2];
      logic s;
      addrs = '{int'(d_rs_addr), int'(d_rt_addr)};
      tuses = '{int'(d_tuse_rs), int'(d_tuse_rt)};
      s = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (tuses[k] != 3 && addrs[k] != 0) begin
            if (addrs[k] == int'(e_waddr) && tuses[k] < int'(e_tnew)) s = 1'b1;
            if (addrs[k] == int'(m_waddr) && tuses[k] < int'(m_tnew)) s = 1'b1;
         end
      end
      if (d_is_md && (md_start || cyc <= busy_end)) s = 1'b1;
      return s;
   endfunction

   // Advance one clock; inputs are changed only #1 after the edge, so the
   // values read here are exactly what the DUT sampled.
   task automatic step();
      @(posedge clk);
      if (!reset)        busy_end = -1;
      else if (md_start) busy_end = cyc + (md_is_div ? 10 : 5);
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      d_rs_addr = 0; d_rt_addr = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_is_md = 0;
      e_rs_addr = 0; e_rt_addr = 0; e_waddr = 0; e_tnew = 0;
      m_waddr = 0; m_tnew = 0; w_waddr = 0; w_src = 0;
      md_start = 0; md_is_div = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      md_start = 1; md_is_div = 1; d_is_md = 1;
      d_rs_addr = 5; d_rt_addr = 6; d_tuse_rs = 0; d_tuse_rt = 0;
      e_rs_addr = 5; e_rt_addr = 6;
      e_waddr = 5; e_tnew = 2; m_waddr = 5; m_tnew = 0; w_waddr = 6; w_src = 0;
      step(); step();
      if ({fwd_sel_d_rs, fwd_sel_d_rt, fwd_sel_e_rs, fwd_sel_e_rt} !== 12'd0) begin
         bad++;
         $display("FAIL reset_sel: got %h %h %h %h expected 0 0 0 0",
                  fwd_sel_d_rs, fwd_sel_d_rt, fwd_sel_e_rs, fwd_sel_e_rt);
      end
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
      total++;
      if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
      total++;
      clear_inputs();
      reset = 1'b1;
      step();
      if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b expected 0", md_busy); end
      total++;
   endtask

   task automatic test_alu_fwd();
      clear_inputs();
      m_waddr = 8; m_tnew = 0; w_waddr = 8; w_src = 1; d_rs_addr = 8;
      #1;
      if (fwd_sel_d_rs !== 3'd1) begin bad++; $display("FAIL alu_fwd_m_over_w: got %0d expected 1", fwd_sel_d_rs); end
      total++;
      m_waddr = 0;
      #1;
      if (fwd_sel_d_rs !== 3'd3) begin bad++; $display("FAIL alu_fwd_w_md: got %0d expected 3", fwd_sel_d_rs); end
      total++;
      m_waddr = 8; m_tnew = 1;   // M result not ready yet: fall back to W
      #1;
      if (fwd_sel_d_rs !== 3'd3) begin bad++; $display("FAIL alu_fwd_m_not_ready: got %0d expected 3", fwd_sel_d_rs); end
      total++;
   endtask

   task automatic test_load_use();
      clear_inputs();
      e_waddr = 9; e_tnew = 2; d_rt_addr = 9; d_tuse_rt = 1;
      #1;
      if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall: got %b expected 1", stall); end
      total++;
      d_tuse_rt = 2;
      #1;
      if (stall !== 1'b0) begin bad++; $display("FAIL load_use_tuse_ok: got %b expected 0", stall); end
      total++;
      d_tuse_rt = 0; d_rt_addr = 0; e_waddr = 0;
      #1;
      if (stall !== 1'b0) begin bad++; $display("FAIL load_use_r0: got %b expected 0", stall); end
      total++;
      d_rt_addr = 9; e_waddr = 9; d_tuse_rt = 3;   // operand unused
      #1;
      if (stall !== 1'b0) begin bad++; $display("FAIL load_use_unused: got %b expected 0", stall); end
      total++;
   endtask

   task automatic test_cp0_to_e();
      clear_inputs();
      w_waddr = 12; w_src = 2; e_rt_addr = 12;
      #1;
      if (fwd_sel_e_rt !== 3'd4) begin bad++; $display("FAIL cp0_e_rt: got %0d expected 4", fwd_sel_e_rt); end
      total++;
      w_src = 3;
      #1;
      if (fwd_sel_e_rt !== 3'd0) begin bad++; $display("FAIL mem_e_rt: got %0d expected 0", fwd_sel_e_rt); end
      total++;
   endtask

   // Issue one MD op with a dependent MD instruction held in D and check the
   // busy window and the stall cycle by cycle.
   task automatic run_md(input logic is_div, input int len, input string tag);
      int seen;
      seen = 0;
      d_is_md = 1; md_start = 1; md_is_div = is_div;
      #1;
      if (stall !== 1'b1) begin bad++; $display("FAIL %s_start_stall: got %b expected 1", tag, stall); end
      total++;
      step();
      md_start = 0; md_is_div = 0;
      #1;
      for (int i = 0; i < len + 4; i++) begin
         if (md_busy !== (i < len)) begin
            bad++; $display("FAIL %s_busy_c%0d: got %b expected %b", tag, i, md_busy, (i < len));
         end
         total++;
         if (stall !== (i < len)) begin
            bad++; $display("FAIL %s_stall_c%0d: got %b expected %b", tag, i, stall, (i < len));
         end
         total++;
         if (md_busy === 1'b1) seen++;
         step();
      end
      if (seen != len) begin bad++; $display("FAIL %s_busy_len: got %0d expected %0d", tag, seen, len); end
      total++;
   endtask

   task automatic test_md_seq();
      clear_inputs();
      run_md(1'b1, 10, "div");
      run_md(1'b0, 5, "mult");
   endtask

   task automatic test_reset_mid_div();
      clear_inputs();
      d_is_md = 1; md_start = 1; md_is_div = 1;
      step();
      md_start = 0; md_is_div = 0;
      step(); step(); step();
      if (md_busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy_before: got %b expected 1", md_busy); end
      total++;
      reset = 1'b0;
      #1;
      if (md_busy !== 1'b0) begin bad++; $display("FAIL mid_div_async_clear: got %b expected 0", md_busy); end
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL mid_div_stall_clear: got %b expected 0", stall); end
      total++;
      step();
      reset = 1'b1;
      #1;
      if (stall !== 1'b0) begin bad++; $display("FAIL mid_div_after_release: got %b expected 0", stall); end
      total++;
      run_md(1'b0, 5, "mult_after_rst");
   endtask

   task automatic test_random();
      logic [2:0] e_sel [4];
      logic [2:0] a_sel [4];
      string      names [4];
      names = '{"d_rs", "d_rt", "e_rs", "e_rt"};
      clear_inputs();
      for (int n = 0; n < 400; n++) begin
         d_rs_addr = 5'($urandom_range(0, 3));
         d_rt_addr = 5'($urandom_range(0, 3));
         e_rs_addr = 5'($urandom_range(0, 3));
         e_rt_addr = 5'($urandom_range(0, 3));
         e_waddr   = 5'($urandom_range(0, 3));
         m_waddr   = 5'($urandom_range(0, 3));
         w_waddr   = 5'($urandom_range(0, 3));
         d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom);
         e_tnew    = 2'($urandom); m_tnew    = 2'($urandom);
         w_src     = 2'($urandom);
         d_is_md   = 1'($urandom);
         md_start  = ($urandom_range(0, 11) == 0);
         md_is_div = 1'($urandom);
         #1;
         e_sel = '{ref_sel(d_rs_addr), ref_sel(d_rt_addr), ref_sel(e_rs_addr), ref_sel(e_rt_addr)};
         a_sel = '{fwd_sel_d_rs, fwd_sel_d_rt, fwd_sel_e_rs, fwd_sel_e_rt};
         for (int k = 0; k < 4; k++) begin
            if (a_sel[k] !== e_sel[k]) begin
               bad++; $display("FAIL rand_sel_%s n=%0d: got %0d expected %0d", names[k], n, a_sel[k], e_sel[k]);
            end
            total++;
         end
         if (stall !== ref_stall()) begin
            bad++; $display("FAIL rand_stall n=%0d: got %b expected %b", n, stall, ref_stall());
         end
         total++;
         if (md_busy !== (cyc <= busy_end)) begin
            bad++; $display("FAIL rand_busy n=%0d: got %b expected %b", n, md_busy, (cyc <= busy_end));
         end
         total++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_cp0_to_e();
      test_md_seq();
      test_reset_mid_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
